instr_fetch: RTL

- Fetch stage of the ARK processor. It owns the program counter and drives the address of the instruction ROM (inst_module), which has an asynchronous read.
- It registers the returned instruction word for the downstream decode stage.
- It sequences start, run and halt, and handles redirects from branches.
- It counts retired instructions so benches can check program progress.

---
 rtl/ark_pkg.sv | 26 ++
 rtl/instr_fetch_pc_next.sv | 26 ++
 rtl/instr_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/ark_pkg.sv
// Shared ARK definitions: fetch FSM states, datapath widths and the HALT opcode
// used by both fetch and decode.
package ark_pkg;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_e;

    // Next-PC source chosen by the fetch FSM each cycle.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SEQ,
        PC_ABS,
        PC_REL,
        PC_LOAD
    } pc_sel_e;

    localparam instr_t HALT_OP = 9'h1FF;
endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selector: hold, sequential, absolute, relative and
// start-address load.
module pc_next #(
    parameter int PC_W       = ark_pkg::PC_W,
    parameter int START_ADDR = 0
) (
    input  logic [2:0]      sel,
    input  logic [PC_W-1:0] pc_q,
    input  logic [PC_W-1:0] instr_pc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc_d
);
    import ark_pkg::*;

    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_SEQ:  pc_d = pc_q + PC_W'(1);
            PC_ABS:  pc_d = target;
            // Same-width add is the sign-extended offset taken modulo 2^PC_W.
            PC_REL:  pc_d = instr_pc + target;
            PC_LOAD: pc_d = PC_W'(START_ADDR);
            default: pc_d = pc_q;
        endcase
    end
endmodule

// File: rtl/instr_fetch.sv
// ARK fetch stage: owns the PC, registers ROM data for decode, sequences
// start/run/halt, handles branch redirects and counts retired instructions.
module instr_fetch #(
    parameter int PC_W       = ark_pkg::PC_W,
    parameter int INSTR_W    = ark_pkg::INSTR_W,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic               branch_rel,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt_req,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    output logic               halt,
    output logic [CNT_W-1:0]   retired_cnt
);
    import ark_pkg::*;

    fetch_state_e       state_q, state_d;
    pc_sel_e            pc_sel;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic               valid_q, valid_d;
    logic               halt_q, halt_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               load_instr, retire, clr_cnt;

    pc_next #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR)
    ) u_pc_next (
        .sel      (pc_sel),
        .pc_q     (pc_q),
        .instr_pc (instr_pc_q),
        .target   (branch_target),
        .pc_d     (pc_d)
    );

    always_comb begin
        state_d    = state_q;
        pc_sel     = PC_HOLD;
        load_instr = 1'b0;
        valid_d    = valid_q;
        halt_d     = halt_q;
        retire     = 1'b0;
        clr_cnt    = 1'b0;
        if (start) begin
            state_d = RUN;
            pc_sel  = PC_LOAD;
            valid_d = 1'b0;
            halt_d  = 1'b0;
            clr_cnt = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_req && valid_q) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        load_instr = 1'b1;
                        retire     = valid_q;
                        // A taken branch squashes the word fetched this cycle.
                        if (branch_taken && valid_q) begin
                            pc_sel  = branch_rel ? PC_REL : PC_ABS;
                            valid_d = 1'b0;
                        end else begin
                            pc_sel  = PC_SEQ;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= PC_W'(START_ADDR);
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            if (load_instr) begin
                instr_q    <= rom_data;
                instr_pc_q <= pc_q;
            end
            if (clr_cnt)
                cnt_q <= '0;
            else if (retire && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halt        = halt_q;
    assign retired_cnt = cnt_q;
endmodule
